// File: rtl/sp_dram_arbiter_if.sv
// Scratchpad-side load/store requests and the single DRAM request/response port, in one bundle.
// master = arbiter view, slave = scratchpad + DRAM environment view.
interface sp_dram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              sLoad;
   logic [ADDR_W-1:0] load_addr;
   logic              sStore;
   logic [ADDR_W-1:0] store_addr;
   logic [DATA_W-1:0] store_data;
   logic              sLoad_hit;
   logic [DATA_W-1:0] load_data;
   logic              sStore_hit;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_wen;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_wdata;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_rdata;

   modport master (
      input  sLoad, load_addr, sStore, store_addr, store_data,
      output sLoad_hit, load_data, sStore_hit,
      output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      output sLoad, load_addr, sStore, store_addr, store_data,
      input  sLoad_hit, load_data, sStore_hit,
      input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );
endinterface

// File: rtl/sp_dram_arbiter.sv
// Serialises scratchpad loads/stores onto one DRAM port, one transaction in flight, round-robin on ties.
// Latency: request to hit 3 cycles minimum; mem_req_valid holds with a latched request until ready.
module sp_dram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   sp_dram_arbiter_if.master bus,
   output logic             err_unexp_rsp,
   output logic [CNT_W-1:0] load_cnt,
   output logic [CNT_W-1:0] store_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   logic              r_last_st;
   logic              r_wen;
   logic              r_vld;
   logic              r_ld_hit;
   logic              r_st_hit;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_ld_data;
   logic [CNT_W-1:0]  r_ld_cnt;
   logic [CNT_W-1:0]  r_st_cnt;
   logic              w_grant_st;

   // On a tie the kind not granted last time wins; reset value makes load win the first tie.
   assign w_grant_st = bus.sStore && (!bus.sLoad || !r_last_st);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state   <= S_IDLE;
         r_last_st <= 1'b1;
         r_wen     <= 1'b0;
         r_vld     <= 1'b0;
         r_ld_hit  <= 1'b0;
         r_st_hit  <= 1'b0;
         r_err     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_ld_data <= '0;
         r_ld_cnt  <= '0;
         r_st_cnt  <= '0;
      end else begin
         if (bus.mem_rsp_valid && (r_state != S_WAIT)) begin
            r_err <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (bus.sLoad || bus.sStore) begin
                  r_wen     <= w_grant_st;
                  r_last_st <= w_grant_st;
                  r_addr    <= w_grant_st ? bus.store_addr : bus.load_addr;
                  r_wdata   <= w_grant_st ? bus.store_data : '0;
                  r_vld     <= 1'b1;
                  r_state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.mem_req_ready) begin
                  r_vld   <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.mem_rsp_valid) begin
                  if (!r_wen) begin
                     r_ld_data <= bus.mem_rsp_rdata;
                  end
                  r_ld_hit <= !r_wen;
                  r_st_hit <= r_wen;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_ld_hit <= 1'b0;
               r_st_hit <= 1'b0;
               if (r_wen) begin
                  r_st_cnt <= r_st_cnt + CNT_W'(1);
               end else begin
                  r_ld_cnt <= r_ld_cnt + CNT_W'(1);
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_req_valid = r_vld;
   assign bus.mem_req_wen   = r_wen;
   assign bus.mem_req_addr  = r_addr;
   assign bus.mem_req_wdata = r_wdata;
   assign bus.sLoad_hit     = r_ld_hit;
   assign bus.sStore_hit    = r_st_hit;
   assign bus.load_data     = r_ld_data;
   assign err_unexp_rsp     = r_err;
   assign load_cnt          = r_ld_cnt;
   assign store_cnt         = r_st_cnt;

endmodule

// File: tb/tb_sp_dram_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_sp_dram_arbiter;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int CW = 2;

   logic          CLK  = 1'b0;
   logic          nRST = 1'b0;
   logic          err_unexp_rsp;
   logic [CW-1:0] load_cnt;
   logic [CW-1:0] store_cnt;

   sp_dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sp_dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .bus           (bus),
      .err_unexp_rsp (err_unexp_rsp),
      .load_cnt      (load_cnt),
      .store_cnt     (store_cnt)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;
   int w;
   logic [DW-1:0] last_rd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.sLoad = 1'b0;  bus.load_addr = '0;
      bus.sStore = 1'b0; bus.store_addr = '0; bus.store_data = '0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      idle_inputs();
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
   endtask

   // Plays the DRAM side for one transaction; the requester drops its request on the hit.
   task automatic serve(input bit exp_st, input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wdata,
                        input int rdy_dly, input logic [DW-1:0] rdata, output int waited);
      bit seen = 1'b0;
      waited = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLK);
         if (bus.mem_req_valid) seen = 1'b1;
         else waited++;
      end
      chk("req_seen", 64'(seen), 64'd1);
      if (!seen) return;
      for (int i = 0; i <= rdy_dly; i++) begin
         if (i > 0) @(negedge CLK);
         chk("req_vld", 64'(bus.mem_req_valid), 64'd1);
         chk("req_wen", 64'(bus.mem_req_wen), 64'(exp_st));
         chk("req_addr", 64'(bus.mem_req_addr), 64'(exp_addr));
         chk("req_wdata", bus.mem_req_wdata, exp_wdata);
         bus.mem_req_ready = (i == rdy_dly);
      end
      @(negedge CLK);
      bus.mem_req_ready = 1'b0;
      chk("req_drop", 64'(bus.mem_req_valid), 64'd0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = rdata;
      @(negedge CLK);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      chk("hit_ld", 64'(bus.sLoad_hit), 64'(!exp_st));
      chk("hit_st", 64'(bus.sStore_hit), 64'(exp_st));
      if (exp_st) bus.sStore = 1'b0;
      else        bus.sLoad  = 1'b0;
      @(negedge CLK);
      chk("hit_once", 64'({bus.sLoad_hit, bus.sStore_hit}), 64'd0);
   endtask

   // Random-phase model state
   bit            pl, ps, busy, acc, kst, hit_due, prev_vld, rdy_drv, last_st, rsp_sent;
   int            rsp_dly, idle_cnt, nl, ns;
   logic [AW-1:0] la, sa, ta;
   logic [DW-1:0] sd, td, rd, exp_ld;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      nRST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_vld", 64'(bus.mem_req_valid), 64'd0);
      chk("rst_hits", 64'({bus.sLoad_hit, bus.sStore_hit}), 64'd0);
      chk("rst_data", bus.load_data, 64'd0);
      chk("rst_err", 64'(err_unexp_rsp), 64'd0);
      chk("rst_cnt", 64'({load_cnt, store_cnt}), 64'd0);
      nRST = 1'b1;

      // single load at minimum latency
      @(negedge CLK);
      bus.sLoad = 1'b1; bus.load_addr = 32'h1000;
      serve(1'b0, 32'h1000, 64'd0, 0, 64'hDEAD_BEEF, w);
      chk("t1_lat", 64'(w), 64'd0);
      chk("t1_data", bus.load_data, 64'hDEAD_BEEF);
      chk("t1_cnt", 64'(load_cnt), 64'd1);

      // store with ready held low; live inputs change but the request must not
      bus.sStore = 1'b1; bus.store_addr = 32'h2000; bus.store_data = 64'h55;
      fork
         serve(1'b1, 32'h2000, 64'h55, 5, 64'h0BAD, w);
         begin
            repeat (3) @(negedge CLK);
            bus.store_addr = 32'h3333; bus.store_data = 64'hAA;
         end
      join
      chk("t2_data", bus.load_data, 64'hDEAD_BEEF);
      chk("t2_scnt", 64'(store_cnt), 64'd1);

      // ties alternate, load first after reset
      do_reset();
      bus.sLoad = 1'b1; bus.load_addr = 32'h10; bus.sStore = 1'b1; bus.store_addr = 32'h20; bus.store_data = 64'h77;
      serve(1'b0, 32'h10, 64'd0, 1, 64'h111, w);
      serve(1'b1, 32'h20, 64'h77, 0, 64'h0, w);
      chk("t3_b2b", 64'(w), 64'd0);
      bus.sLoad = 1'b1; bus.load_addr = 32'h30; bus.sStore = 1'b1; bus.store_addr = 32'h40; bus.store_data = 64'h88;
      serve(1'b0, 32'h30, 64'd0, 2, 64'h222, w);
      serve(1'b1, 32'h40, 64'h88, 1, 64'h0, w);
      chk("t3_cnts", 64'({load_cnt, store_cnt}), 64'({2'd2, 2'd2}));

      // request withdrawn mid-transaction still completes
      bus.sLoad = 1'b1; bus.load_addr = 32'h50;
      fork
         serve(1'b0, 32'h50, 64'd0, 3, 64'h333, w);
         begin
            repeat (2) @(negedge CLK);
            bus.sLoad = 1'b0;
         end
      join
      chk("t3_wdr_cnt", 64'(load_cnt), 64'd3);
      last_rd = 64'h333;

      // spurious response in IDLE
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 64'h1234;
      @(negedge CLK);
      bus.mem_rsp_valid = 1'b0;
      chk("t4_hits", 64'({bus.sLoad_hit, bus.sStore_hit}), 64'd0);
      chk("t4_err", 64'(err_unexp_rsp), 64'd1);
      chk("t4_data", bus.load_data, last_rd);
      repeat (3) @(negedge CLK);
      chk("t4_idle", 64'(bus.mem_req_valid), 64'd0);
      bus.sStore = 1'b1; bus.store_addr = 32'h60; bus.store_data = 64'h99;
      serve(1'b1, 32'h60, 64'h99, 0, 64'h0, w);
      chk("t4_sticky", 64'(err_unexp_rsp), 64'd1);

      // reset while waiting for the response
      do_reset();
      bus.sLoad = 1'b1; bus.load_addr = 32'h70;
      for (int i = 0; i < 10 && !bus.mem_req_valid; i++) @(negedge CLK);
      chk("t5_req", 64'(bus.mem_req_valid), 64'd1);
      bus.mem_req_ready = 1'b1;
      @(negedge CLK);
      bus.mem_req_ready = 1'b0;
      chk("t5_wait", 64'(bus.mem_req_valid), 64'd0);
      nRST = 1'b0;
      @(negedge CLK);
      chk("t5_rst_out", 64'({bus.mem_req_valid, bus.sLoad_hit, bus.sStore_hit, err_unexp_rsp}), 64'd0);
      nRST = 1'b1; bus.sLoad = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 64'hBAD;
      @(negedge CLK);
      bus.mem_rsp_valid = 1'b0;
      chk("t5_err", 64'(err_unexp_rsp), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("t5_nohit", 64'({bus.sLoad_hit, bus.sStore_hit}), 64'd0);
         @(negedge CLK);
      end
      chk("t5_data", bus.load_data, 64'd0);

      // counter wrap
      for (int k = 1; k <= 5; k++) begin
         bus.sLoad = 1'b1; bus.load_addr = 32'(k * 8);
         serve(1'b0, 32'(k * 8), 64'd0, 0, 64'(k), w);
         chk("t6_wrap", 64'(load_cnt), 64'(k % 4));
      end

      // randomized traffic against the transaction model
      do_reset();
      pl = 0; ps = 0; busy = 0; acc = 0; kst = 0; hit_due = 0; prev_vld = 0; rdy_drv = 0;
      last_st = 1; rsp_sent = 0; rsp_dly = 0; idle_cnt = 0; nl = 0; ns = 0; exp_ld = '0; rd = '0;
      la = '0; sa = '0; sd = '0; ta = '0; td = '0;
      repeat (3000) begin
         @(negedge CLK);
         if (busy && !acc && prev_vld && rdy_drv) acc = 1;
         chk("r_ld_hit", 64'(bus.sLoad_hit), 64'(hit_due && !kst));
         chk("r_st_hit", 64'(bus.sStore_hit), 64'(hit_due && kst));
         if (hit_due && !kst) exp_ld = rd;
         chk("r_ld_data", bus.load_data, exp_ld);
         chk("r_ld_cnt", 64'(load_cnt), 64'(nl % 4));
         chk("r_st_cnt", 64'(store_cnt), 64'(ns % 4));
         chk("r_err", 64'(err_unexp_rsp), 64'd0);
         if (bus.mem_req_valid) begin
            if (!busy) begin
               chk("r_grant_pend", 64'(pl || ps), 64'd1);
               kst = (pl && ps) ? !last_st : ps;
               last_st = kst;
               busy = 1; acc = 0; rsp_sent = 0; idle_cnt = 0;
               rsp_dly = $urandom_range(0, 3);
               ta = kst ? sa : la;
               td = kst ? sd : '0;
            end
            chk("r_vld_phase", 64'(acc), 64'd0);
            chk("r_wen", 64'(bus.mem_req_wen), 64'(kst));
            chk("r_addr", 64'(bus.mem_req_addr), 64'(ta));
            chk("r_wdata", bus.mem_req_wdata, td);
         end else if (busy && !acc) begin
            chk("r_vld_hold", 64'd0, 64'd1);
         end else if (!busy && (pl || ps)) begin
            idle_cnt++;
            chk("r_grant_lat", 64'(idle_cnt > 1), 64'd0);
         end else begin
            idle_cnt = 0;
         end
         if (hit_due) begin
            if (kst) begin ns++; ps = 0; bus.sStore = 1'b0; end
            else     begin nl++; pl = 0; bus.sLoad  = 1'b0; end
            busy = 0; hit_due = 0;
         end
         bus.mem_rsp_valid = 1'b0;
         if (busy && acc && !rsp_sent) begin
            if (rsp_dly == 0) begin
               rd = {$urandom, $urandom};
               bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = rd;
               rsp_sent = 1; hit_due = 1;
            end else begin
               rsp_dly--;
            end
         end
         rdy_drv = ($urandom_range(0, 1) == 1);
         bus.mem_req_ready = rdy_drv;
         prev_vld = bus.mem_req_valid;
         if (!pl && $urandom_range(0, 3) == 0) begin
            pl = 1; la = $urandom;
            bus.sLoad = 1'b1; bus.load_addr = la;
         end
         if (!ps && $urandom_range(0, 3) == 0) begin
            ps = 1; sa = $urandom; sd = {$urandom, $urandom};
            bus.sStore = 1'b1; bus.store_addr = sa; bus.store_data = sd;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
